// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - FFT sink frame sequencer (sop/eop framing, back-pressure, gap)
// Optional frame counter output enabled by FFT_FRAME_CNT_EN.
module fft_frame_ctrl #(
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 16,
  parameter int GAP_CYC   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic             sample_en,
  input  logic             sink_ready,
  output logic             sink_valid,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [CNT_W-1:0] sample_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
`ifdef FFT_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0] frame_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = '0;

  state_t           state, state_nx;
  logic [CNT_W-1:0] idx, idx_nx;
  logic [CNT_W-1:0] gap_cnt, gap_nx;
  logic             ovr_nx;
  logic             done_nx;
  logic             start_acc;
  logic             xfer;
  logic             last_xfer;

  // Handshake decode is purely combinational so a strobe is offered in its own cycle.
  assign xfer       = (state == STREAM) && sample_en && sink_ready;
  assign last_xfer  = xfer && (idx == LAST_IDX);
  assign sink_valid = xfer;
  assign sink_sop   = xfer && (idx == ZERO);
  assign sink_eop   = last_xfer;
  assign sample_idx = idx;
  assign busy       = (state != IDLE);
  assign start_acc  = (state == IDLE) && start && !stop;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    gap_nx   = gap_cnt;
    ovr_nx   = overrun;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_nx = STREAM;
          idx_nx   = ZERO;
          ovr_nx   = 1'b0;
        end
      end
      STREAM: begin
        if (sample_en && !sink_ready) ovr_nx = 1'b1;
        if (xfer) idx_nx = last_xfer ? ZERO : idx + ONE;
        if (last_xfer) begin
          done_nx = 1'b1;
          if (!cont) begin
            state_nx = IDLE;
          end else if (GAP_CYC > 0) begin
            state_nx = GAP;
            gap_nx   = GAP_LOAD;
          end
        end
        // stop overrides any re-arm decision, but the completed frame still reports done
        if (stop) begin
          state_nx = IDLE;
          idx_nx   = ZERO;
        end
      end
      GAP: begin
        if (gap_cnt == ZERO) begin
          state_nx = STREAM;
          idx_nx   = ZERO;
        end else begin
          gap_nx = gap_cnt - ONE;
        end
        if (stop) begin
          state_nx = IDLE;
          idx_nx   = ZERO;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= ZERO;
      gap_cnt    <= ZERO;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      gap_cnt    <= gap_nx;
      overrun    <= ovr_nx;
      frame_done <= done_nx;
    end
  end

`ifdef FFT_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= ZERO;
    end else if (start_acc) begin
      frame_cnt <= ZERO;
    end else if (done_nx) begin
      frame_cnt <= frame_cnt + ONE;
    end
  end
`endif

endmodule
